cv32e40p_register_file_mp: RTL and testbench
============================================

Name: cv32e40p_register_file_mp

Overview:
Parametrised multi-port integer/FP register file: N read ports, M write ports, optional same-cycle write-through bypass, and a pending-write scoreboard for multi-cycle producers.
- Replaces the fixed 3R/2W register file in the ID stage.
- Lets extra writeback channels (FPU, LSU, accelerator) commit independently.
- Lets hazard logic query per-operand busy status directly from the register file.

Parameters:
ADDR_WIDTH, 6, register address width; bit 5 selects FP bank when FPU=1 and PULP_ZFINX=0
DATA_WIDTH, 32, register width
FPU, 0, 1 = instantiate a 32-entry FP bank
PULP_ZFINX, 0, 1 = FP operands use the integer bank; no FP bank
NUM_RPORTS, 3, number of read ports (1..4)
NUM_WPORTS, 2, number of write ports (1..4)
WRITE_THROUGH, 0, 1 = read returns same-cycle write data
SCOREBOARD, 1, 1 = implement pending-write tracking

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
raddr_i  in  NUM_RPORTS x ADDR_WIDTH  read addresses
rdata_o  out  NUM_RPORTS x DATA_WIDTH  read data
rbusy_o  out  NUM_RPORTS  addressed register has pending write
waddr_i  in  NUM_WPORTS x ADDR_WIDTH  write addresses
wdata_i  in  NUM_WPORTS x DATA_WIDTH  write data
we_i  in  NUM_WPORTS  write enables
rsv_valid_i  in  1  reserve destination for an in-flight producer
rsv_addr_i  in  ADDR_WIDTH  reserved address
any_busy_o  out  1  OR of all pending bits

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Banks:
  - NUM_WORDS = 32 integer registers.
  - Plus 32 FP registers when FPU=1 and PULP_ZFINX=0.
  - Otherwise the upper address bit is ignored and only the integer bank is used.
- Storage is flip-flops with per-word enables, rising edge of clk.
  - Each word is clock-gated via pulp_clock_gating, en = OR of matching we_i.
  - A global gate is driven by OR of all we_i.
- Reset (rst=1, async): all registers 0, all pending bits 0.
  - Hence rdata_o=0, rbusy_o=0, any_busy_o=0.
  - rst asserted mid-write: the write is lost; the word reads 0 after reset.
- x0 behaviour:
  - x0 reads 0 always.
  - Writes to x0 are dropped.
  - Reservations of x0 are dropped.
- FP bank: f0 is an ordinary writable register.
- Write latency: data written at edge t is visible on rdata_o after edge t (0-cycle read of storage).
- Read path is combinational from storage.
- WRITE_THROUGH=1:
  - If any we_i[p] matches raddr_i[r] (x0 excluded), rdata_o[r] = that wdata in the same cycle.
  - The highest matching port index wins.
- Write collision, same address on several ports in one cycle: the highest port index wins. No error flag.
- Scoreboard (SCOREBOARD=1): pending[NUM_TOT_WORDS] flops.
  - rsv_valid_i sets pending[rsv_addr_i] at the edge.
  - Any we_i to address a clears pending[a] at the edge.
  - Reserve and write to the same address in the same cycle: pending ends 1 (new producer wins).
- rbusy_o[r] = pending[raddr_i[r]], combinational.
  - With WRITE_THROUGH=1, a same-cycle write to that address masks rbusy_o[r] to 0, unless a same-cycle reservation targets the same address.
- SCOREBOARD=0: rbusy_o=0, any_busy_o=0; rsv inputs are ignored.
- Writes to a non-pending register are legal; pending is unchanged (stays 0).
- Duplicate reservation of an already pending register: pending stays 1; no counting.

Decomposition:
- Package cv32e40p_rf_pkg holds:
  - the NUM_TOT_WORDS function(FPU, PULP_ZFINX),
  - typedef rf_addr_t (logic [ADDR_WIDTH-1:0]),
  - the REG_ZERO constant,
  - a helper function for highest-index priority select.
- One sub-module: cv32e40p_rf_scoreboard.
  - Contains the pending vector, set/clear logic and busy lookups.
  - Instantiated only under SCOREBOARD=1.

Test Plan:
- Reset, then read all 64 addresses → all 0. Assert rst mid-run after writes → next read 0, rbusy 0.
- Port 0 writes x5=0xDEADBEEF while port 1 writes x5=0x12345678 in the same cycle → x5 reads 0x12345678. Write x0=0xFFFFFFFF → reads 0.
- WRITE_THROUGH=1, FPU=1: write f3=0xA5A5A5A5 (addr 35) with raddr_i[2]=35 in the same cycle → rdata_o[2]=0xA5A5A5A5 that cycle. WRITE_THROUGH=0 → old value (0) that cycle, new value next cycle.
- Reserve x7; next cycle raddr x7 → rbusy=1, any_busy=1. Write x7=0x11 → after the edge rbusy=0, any_busy=0, rdata=0x11.
- Same cycle: reserve x9 and write x9=0x22 → after the edge x9=0x22 and rbusy=1. Reserve x0 → any_busy stays 0.
- PULP_ZFINX=1, FPU=1: write addr 37 → x5 is updated. Random 4R/4W regression against a reference model → no mismatch over 10k cycles.

Source files
------------

// File: rtl/cv32e40p_rf_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
package cv32e40p_rf_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 6;
    localparam int unsigned MAX_PORTS     = 4;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

    localparam rf_addr_t REG_ZERO = '0;

    // Total number of storage words: integer bank plus optional FP bank.
    function automatic int unsigned num_tot_words(input bit fpu, input bit zfinx);
        return (fpu && !zfinx) ? 32'd64 : 32'd32;
    endfunction

    // Index of the highest set bit in a port match vector (0 when none set).
    function automatic logic [1:0] hi_sel(input logic [MAX_PORTS-1:0] match);
        logic [1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (match[i]) sel = 2'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/cv32e40p_rf_scoreboard.sv
// Pending-write tracker: one bit per word, set by reservations, cleared by writes.
module cv32e40p_rf_scoreboard
    import cv32e40p_rf_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 32,
    parameter int unsigned IDX_W         = 5,
    parameter int unsigned NUM_RPORTS    = 3,
    parameter int unsigned NUM_WPORTS    = 2,
    parameter int unsigned WRITE_THROUGH = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rsv_en_i,
    input  logic [IDX_W-1:0]              rsv_idx_i,
    input  logic [NUM_WPORTS-1:0]         wen_i,
    input  logic [NUM_WPORTS*IDX_W-1:0]   widx_i,
    input  logic [NUM_RPORTS*IDX_W-1:0]   ridx_i,
    output logic [NUM_RPORTS-1:0]         rbusy_o,
    output logic                          any_busy_o
);

    logic [NUM_WORDS-1:0] pend_q;
    logic [NUM_WORDS-1:0] pend_d;
    logic [IDX_W-1:0]     ridx;
    logic                 wr_hit;

    // Writes clear first, then a reservation sets, so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            if (wen_i[p]) pend_d[widx_i[p*IDX_W +: IDX_W]] = 1'b0;
        end
        if (rsv_en_i) pend_d[rsv_idx_i] = 1'b1;
    end

    // Pending bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Per-read-port busy lookup, masked by a same-cycle write when bypassing.
    always_comb begin
        rbusy_o = '0;
        ridx    = '0;
        wr_hit  = 1'b0;
        for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
            ridx   = ridx_i[r*IDX_W +: IDX_W];
            wr_hit = 1'b0;
            for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
                if (wen_i[p] && (widx_i[p*IDX_W +: IDX_W] == ridx)) wr_hit = 1'b1;
            end
            rbusy_o[r] = pend_q[ridx];
            if ((WRITE_THROUGH != 0) && wr_hit && !(rsv_en_i && (rsv_idx_i == ridx))) begin
                rbusy_o[r] = 1'b0;
            end
        end
    end

    assign any_busy_o = |pend_q;

endmodule

// File: rtl/cv32e40p_register_file_mp.sv
// Parametrised multi-port integer/FP register file with optional bypass and scoreboard.
module cv32e40p_register_file_mp
    import cv32e40p_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FPU           = 0,
    parameter int unsigned PULP_ZFINX    = 0,
    parameter int unsigned NUM_RPORTS    = 3,
    parameter int unsigned NUM_WPORTS    = 2,
    parameter int unsigned WRITE_THROUGH = 0,
    parameter int unsigned SCOREBOARD    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_RPORTS-1:0]             rbusy_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WPORTS-1:0]             we_i,
    input  logic                              rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]             rsv_addr_i,
    output logic                              any_busy_o
);

    localparam int unsigned NUM_TOT_WORDS = num_tot_words(FPU != 0, PULP_ZFINX != 0);
    // Without an FP bank the upper address bit is simply dropped.
    localparam int unsigned IDX_W         = (NUM_TOT_WORDS > 32) ? 6 : 5;

    logic [IDX_W-1:0]            widx [MAX_PORTS];
    logic [DATA_WIDTH-1:0]       wdat [MAX_PORTS];
    logic [MAX_PORTS-1:0]        wen;
    logic [NUM_WPORTS*IDX_W-1:0] widx_flat;
    logic [IDX_W-1:0]            ridx [NUM_RPORTS];
    logic [NUM_RPORTS*IDX_W-1:0] ridx_flat;
    logic [IDX_W-1:0]            rsv_idx;
    logic                        rsv_en;

    logic [DATA_WIDTH-1:0]       mem_q [NUM_TOT_WORDS];
    logic [DATA_WIDTH-1:0]       mem_d [NUM_TOT_WORDS];
    logic [NUM_TOT_WORDS-1:0]    word_en;
    logic                        wr_any;
    logic [MAX_PORTS-1:0]        wr_hit;
    logic [MAX_PORTS-1:0]        rd_hit;
    logic [DATA_WIDTH-1:0]       rd_val;
    logic                        unused_bits;

    // Unpack write ports to word indices; writes and reservations of x0 are dropped.
    always_comb begin
        for (int unsigned p = 0; p < MAX_PORTS; p++) begin
            widx[p] = '0;
            wdat[p] = '0;
            wen[p]  = 1'b0;
        end
        widx_flat = '0;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            widx[p] = waddr_i[p*ADDR_WIDTH +: IDX_W];
            wdat[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            wen[p]  = we_i[p] && (widx[p] != IDX_W'(REG_ZERO));
            widx_flat[p*IDX_W +: IDX_W] = widx[p];
        end
        rsv_idx = rsv_addr_i[IDX_W-1:0];
        rsv_en  = rsv_valid_i && (rsv_idx != IDX_W'(REG_ZERO));
    end

    // Unpack read port addresses to word indices.
    always_comb begin
        ridx_flat = '0;
        for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
            ridx[r] = raddr_i[r*ADDR_WIDTH +: IDX_W];
            ridx_flat[r*IDX_W +: IDX_W] = ridx[r];
        end
    end

    // Per-word enable and next data; highest matching write port wins a collision.
    always_comb begin
        wr_any = |wen;
        wr_hit = '0;
        for (int unsigned w = 0; w < NUM_TOT_WORDS; w++) begin
            wr_hit = '0;
            for (int unsigned p = 0; p < MAX_PORTS; p++) begin
                wr_hit[p] = wen[p] && (widx[p] == IDX_W'(w));
            end
            word_en[w] = |wr_hit;
            mem_d[w]   = wdat[hi_sel(wr_hit)];
        end
    end

    // Word storage; the global and per-word enables map onto the integrated clock gates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned w = 0; w < NUM_TOT_WORDS; w++) mem_q[w] <= '0;
        end else if (wr_any) begin
            for (int unsigned w = 0; w < NUM_TOT_WORDS; w++) begin
                if (word_en[w]) mem_q[w] <= mem_d[w];
            end
        end
    end

    // Combinational read with x0 forced to zero and optional same-cycle bypass.
    always_comb begin
        rdata_o = '0;
        rd_hit  = '0;
        rd_val  = '0;
        for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
            rd_val = mem_q[ridx[r]];
            if (ridx[r] == IDX_W'(REG_ZERO)) rd_val = '0;
            rd_hit = '0;
            if (WRITE_THROUGH != 0) begin
                for (int unsigned p = 0; p < MAX_PORTS; p++) begin
                    rd_hit[p] = wen[p] && (widx[p] == ridx[r]);
                end
                if (|rd_hit) rd_val = wdat[hi_sel(rd_hit)];
            end
            rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rd_val;
        end
    end

    generate
        if (SCOREBOARD != 0) begin : g_sb
            cv32e40p_rf_scoreboard #(
                .NUM_WORDS     (NUM_TOT_WORDS),
                .IDX_W         (IDX_W),
                .NUM_RPORTS    (NUM_RPORTS),
                .NUM_WPORTS    (NUM_WPORTS),
                .WRITE_THROUGH (WRITE_THROUGH)
            ) u_sb (
                .clk        (clk),
                .rst        (rst),
                .rsv_en_i   (rsv_en),
                .rsv_idx_i  (rsv_idx),
                .wen_i      (wen[NUM_WPORTS-1:0]),
                .widx_i     (widx_flat),
                .ridx_i     (ridx_flat),
                .rbusy_o    (rbusy_o),
                .any_busy_o (any_busy_o)
            );
        end else begin : g_no_sb
            assign rbusy_o    = '0;
            assign any_busy_o = 1'b0;
        end
    endgenerate

    // Address bits above the bank index and scoreboard inputs may be unused in some configurations.
    assign unused_bits = ^{raddr_i, waddr_i, rsv_addr_i, rsv_valid_i, ridx_flat, widx_flat, rsv_idx, rsv_en};

endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Directed and reference-model bench for the multi-port register file.
module tb_cv32e40p_register_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    // Instance A: default configuration (3R/2W, no FP bank, no bypass, scoreboard).
    logic [17:0]  a_raddr;
    logic [95:0]  a_rdata;
    logic [2:0]   a_rbusy;
    logic [11:0]  a_waddr;
    logic [63:0]  a_wdata;
    logic [1:0]   a_we;
    logic         a_rsv_v;
    logic [5:0]   a_rsv_a;
    logic         a_any;

    // Instance B: 4R/4W, FP bank, write-through, scoreboard.
    logic [23:0]  b_raddr;
    logic [127:0] b_rdata;
    logic [3:0]   b_rbusy;
    logic [23:0]  b_waddr;
    logic [127:0] b_wdata;
    logic [3:0]   b_we;
    logic         b_rsv_v;
    logic [5:0]   b_rsv_a;
    logic         b_any;

    // Instance C: FPU with ZFINX (FP operands live in the integer bank).
    logic [17:0]  c_raddr;
    logic [95:0]  c_rdata;
    logic [2:0]   c_rbusy;
    logic [11:0]  c_waddr;
    logic [63:0]  c_wdata;
    logic [1:0]   c_we;
    logic         c_rsv_v;
    logic [5:0]   c_rsv_a;
    logic         c_any;

    cv32e40p_register_file_mp u_dut_a (
        .clk(clk), .rst(rst), .raddr_i(a_raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
        .waddr_i(a_waddr), .wdata_i(a_wdata), .we_i(a_we), .rsv_valid_i(a_rsv_v),
        .rsv_addr_i(a_rsv_a), .any_busy_o(a_any)
    );

    cv32e40p_register_file_mp #(
        .FPU(1), .NUM_RPORTS(4), .NUM_WPORTS(4), .WRITE_THROUGH(1), .SCOREBOARD(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
        .waddr_i(b_waddr), .wdata_i(b_wdata), .we_i(b_we), .rsv_valid_i(b_rsv_v),
        .rsv_addr_i(b_rsv_a), .any_busy_o(b_any)
    );

    cv32e40p_register_file_mp #(
        .FPU(1), .PULP_ZFINX(1)
    ) u_dut_c (
        .clk(clk), .rst(rst), .raddr_i(c_raddr), .rdata_o(c_rdata), .rbusy_o(c_rbusy),
        .waddr_i(c_waddr), .wdata_i(c_wdata), .we_i(c_we), .rsv_valid_i(c_rsv_v),
        .rsv_addr_i(c_rsv_a), .any_busy_o(c_any)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_addr();
        return 6'(($urandom_range(0, 1) * 32) + $urandom_range(0, 7));
    endfunction

    // Reference model state for the random phase on instance B.
    logic [31:0] m_mem  [64];
    logic        m_pend [64];
    logic [5:0]  ra [4];
    logic [5:0]  wa [4];
    logic [31:0] wd [4];
    logic [3:0]  wev;
    logic        rv;
    logic [5:0]  rv_a;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_any;
    logic        e_hit;
    logic [5:0]  a6;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a_raddr = '0; a_waddr = '0; a_wdata = '0; a_we = '0; a_rsv_v = 1'b0; a_rsv_a = '0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_we = '0; b_rsv_v = 1'b0; b_rsv_a = '0;
        c_raddr = '0; c_waddr = '0; c_wdata = '0; c_we = '0; c_rsv_v = 1'b0; c_rsv_a = '0;
        #12;
        rst = 1'b0;
        tick();

        // Every address reads zero after reset.
        for (int a = 0; a < 64; a++) begin
            a6 = 6'(a);
            a_raddr = {a6, a6, a6};
            b_raddr = {a6, a6, a6, a6};
            #1;
            check_eq("rst_a_rdata", a_rdata[31:0], 32'h0);
            check_eq("rst_b_rdata", b_rdata[127:96], 32'h0);
        end
        check_eq("rst_a_rbusy", 32'(a_rbusy), 32'h0);
        check_eq("rst_a_any", 32'(a_any), 32'h0);
        check_eq("rst_b_any", 32'(b_any), 32'h0);

        // Write collision on x5: higher port wins.
        a_waddr = {6'd5, 6'd5};
        a_wdata = {32'h12345678, 32'hDEADBEEF};
        a_we = 2'b11;
        tick();
        a_we = 2'b00;
        a_raddr = {6'd0, 6'd0, 6'd5};
        #1;
        check_eq("collide_x5", a_rdata[31:0], 32'h12345678);

        // x0 writes are dropped.
        a_waddr = {6'd0, 6'd0};
        a_wdata = {32'h0, 32'hFFFFFFFF};
        a_we = 2'b01;
        tick();
        a_we = 2'b00;
        a_raddr = {6'd0, 6'd0, 6'd0};
        #1;
        check_eq("x0_read", a_rdata[31:0], 32'h0);

        // No bypass: address 35 aliases x3; old value this cycle, new value after the edge.
        a_waddr = {6'd0, 6'd35};
        a_wdata = {32'h0, 32'hA5A5A5A5};
        a_we = 2'b01;
        a_raddr = {6'd35, 6'd0, 6'd3};
        #1;
        check_eq("wt0_same_cycle", a_rdata[95:64], 32'h0);
        tick();
        a_we = 2'b00;
        #1;
        check_eq("wt0_next_cycle", a_rdata[95:64], 32'hA5A5A5A5);
        check_eq("wt0_alias_x3", a_rdata[31:0], 32'hA5A5A5A5);

        // Reserve x7, then its producer writes back.
        a_rsv_v = 1'b1; a_rsv_a = 6'd7;
        tick();
        a_rsv_v = 1'b0;
        a_raddr = {6'd0, 6'd7, 6'd0};
        #1;
        check_eq("rsv_x7_rbusy", 32'(a_rbusy[1]), 32'h1);
        check_eq("rsv_x7_any", 32'(a_any), 32'h1);
        a_waddr = {6'd0, 6'd7};
        a_wdata = {32'h0, 32'h11};
        a_we = 2'b01;
        tick();
        a_we = 2'b00;
        #1;
        check_eq("wb_x7_rbusy", 32'(a_rbusy[1]), 32'h0);
        check_eq("wb_x7_any", 32'(a_any), 32'h0);
        check_eq("wb_x7_rdata", a_rdata[63:32], 32'h11);

        // Reserve and write x9 in the same cycle: data lands, pending stays set.
        a_rsv_v = 1'b1; a_rsv_a = 6'd9;
        a_waddr = {6'd9, 6'd0};
        a_wdata = {32'h22, 32'h0};
        a_we = 2'b10;
        tick();
        a_rsv_v = 1'b0;
        a_we = 2'b00;
        a_raddr = {6'd0, 6'd0, 6'd9};
        #1;
        check_eq("rsvwr_x9_rdata", a_rdata[31:0], 32'h22);
        check_eq("rsvwr_x9_rbusy", 32'(a_rbusy[0]), 32'h1);
        check_eq("rsvwr_x9_any", 32'(a_any), 32'h1);

        // Without bypass a same-cycle write does not hide the busy bit.
        a_waddr = {6'd0, 6'd9};
        a_wdata = {32'h0, 32'h23};
        a_we = 2'b01;
        #1;
        check_eq("wt0_busy_unmasked", 32'(a_rbusy[0]), 32'h1);
        tick();
        a_we = 2'b00;
        #1;
        check_eq("clr_x9_rbusy", 32'(a_rbusy[0]), 32'h0);
        check_eq("clr_x9_any", 32'(a_any), 32'h0);
        check_eq("clr_x9_rdata", a_rdata[31:0], 32'h23);

        // Reservations of x0 (and its alias 32 without an FP bank) are dropped.
        a_rsv_v = 1'b1; a_rsv_a = 6'd0;
        tick();
        check_eq("rsv_x0_any", 32'(a_any), 32'h0);
        a_rsv_a = 6'd32;
        tick();
        a_rsv_v = 1'b0;
        #1;
        check_eq("rsv_x32_alias_any", 32'(a_any), 32'h0);

        // Duplicate reservation does not count: one write clears it.
        a_rsv_v = 1'b1; a_rsv_a = 6'd10;
        tick();
        tick();
        a_rsv_v = 1'b0;
        a_waddr = {6'd0, 6'd10};
        a_wdata = {32'h0, 32'h3};
        a_we = 2'b01;
        tick();
        a_we = 2'b00;
        #1;
        check_eq("dup_rsv_any", 32'(a_any), 32'h0);

        // Asynchronous reset in the middle of a write.
        a_waddr = {6'd0, 6'd12};
        a_wdata = {32'h0, 32'h55};
        a_we = 2'b01;
        tick();
        a_we = 2'b00;
        a_rsv_v = 1'b1; a_rsv_a = 6'd13;
        tick();
        a_rsv_v = 1'b0;
        a_raddr = {6'd13, 6'd12, 6'd5};
        #1;
        check_eq("pre_rst_x12", a_rdata[63:32], 32'h55);
        check_eq("pre_rst_busy13", 32'(a_rbusy[2]), 32'h1);
        a_waddr = {6'd0, 6'd5};
        a_wdata = {32'h0, 32'h99};
        a_we = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        check_eq("in_rst_x12", a_rdata[63:32], 32'h0);
        check_eq("in_rst_busy13", 32'(a_rbusy[2]), 32'h0);
        check_eq("in_rst_any", 32'(a_any), 32'h0);
        a_we = 2'b00;
        #1;
        rst = 1'b0;
        tick();
        check_eq("post_rst_x5", a_rdata[31:0], 32'h0);
        check_eq("post_rst_x12", a_rdata[63:32], 32'h0);
        check_eq("post_rst_busy13", 32'(a_rbusy[2]), 32'h0);

        // Bypass with FP bank: f3 visible in the write cycle, x3 untouched.
        b_waddr = {6'd0, 6'd0, 6'd35, 6'd0};
        b_wdata = {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
        b_we = 4'b0010;
        b_raddr = {6'd3, 6'd35, 6'd0, 6'd0};
        #1;
        check_eq("wt1_f3_same", b_rdata[95:64], 32'hA5A5A5A5);
        check_eq("wt1_x3_same", b_rdata[127:96], 32'h0);
        tick();
        b_we = 4'b0000;
        #1;
        check_eq("wt1_f3_next", b_rdata[95:64], 32'hA5A5A5A5);
        check_eq("wt1_x3_next", b_rdata[127:96], 32'h0);

        // f0 is an ordinary register; x0 stays zero.
        b_waddr = {6'd0, 6'd0, 6'd0, 6'd32};
        b_wdata = {32'h0, 32'h0, 32'h0, 32'h77};
        b_we = 4'b0001;
        tick();
        b_we = 4'b0000;
        b_raddr = {6'd0, 6'd0, 6'd0, 6'd32};
        #1;
        check_eq("f0_rdata", b_rdata[31:0], 32'h77);
        check_eq("x0_vs_f0", b_rdata[63:32], 32'h0);

        // Bypass collision between ports 0 and 3 on x6.
        b_waddr = {6'd6, 6'd0, 6'd0, 6'd6};
        b_wdata = {32'hBBBB0003, 32'h0, 32'h0, 32'hAAAA0000};
        b_we = 4'b1001;
        b_raddr = {6'd0, 6'd0, 6'd0, 6'd6};
        #1;
        check_eq("wt1_collide_same", b_rdata[31:0], 32'hBBBB0003);
        tick();
        b_we = 4'b0000;
        #1;
        check_eq("wt1_collide_next", b_rdata[31:0], 32'hBBBB0003);

        // Bypass busy masking, and its cancellation by a same-cycle reservation.
        b_rsv_v = 1'b1; b_rsv_a = 6'd8;
        tick();
        b_rsv_v = 1'b0;
        b_waddr = {6'd0, 6'd0, 6'd0, 6'd8};
        b_wdata = {32'h0, 32'h0, 32'h0, 32'h1};
        b_we = 4'b0001;
        b_raddr = {6'd0, 6'd0, 6'd0, 6'd8};
        #1;
        check_eq("wt1_busy_masked", 32'(b_rbusy[0]), 32'h0);
        check_eq("wt1_bypass_x8", b_rdata[31:0], 32'h1);
        b_rsv_v = 1'b1; b_rsv_a = 6'd8;
        #1;
        check_eq("wt1_busy_rsv_same", 32'(b_rbusy[0]), 32'h1);
        tick();
        b_rsv_v = 1'b0;
        b_we = 4'b0000;
        #1;
        check_eq("wt1_busy_after", 32'(b_rbusy[0]), 32'h1);
        check_eq("wt1_any_after", 32'(b_any), 32'h1);
        check_eq("wt1_x8_after", b_rdata[31:0], 32'h1);
        b_wdata = {32'h0, 32'h0, 32'h0, 32'h2};
        b_we = 4'b0001;
        tick();
        b_we = 4'b0000;
        #1;
        check_eq("wt1_any_clear", 32'(b_any), 32'h0);

        // ZFINX: address 37 lands in x5.
        c_waddr = {6'd0, 6'd37};
        c_wdata = {32'h0, 32'h0000CAFE};
        c_we = 2'b01;
        tick();
        c_we = 2'b00;
        c_raddr = {6'd0, 6'd37, 6'd5};
        #1;
        check_eq("zfinx_x5", c_rdata[31:0], 32'h0000CAFE);
        check_eq("zfinx_37", c_rdata[63:32], 32'h0000CAFE);

        // Random regression on instance B against a reference model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
        tick();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                ra[p] = rnd_addr();
                wa[p] = rnd_addr();
                wd[p] = $urandom;
                wev[p] = 1'($urandom_range(0, 1));
                b_raddr[p*6 +: 6] = ra[p];
                b_waddr[p*6 +: 6] = wa[p];
                b_wdata[p*32 +: 32] = wd[p];
            end
            rv = ($urandom_range(0, 3) == 0);
            rv_a = rnd_addr();
            b_we = wev;
            b_rsv_v = rv;
            b_rsv_a = rv_a;
            #1;
            e_any = 1'b0;
            for (int w = 0; w < 64; w++) e_any = e_any | m_pend[w];
            for (int r = 0; r < 4; r++) begin
                e_data = (ra[r] == 6'd0) ? 32'h0 : m_mem[ra[r]];
                e_hit = 1'b0;
                for (int p = 0; p < 4; p++) begin
                    if (wev[p] && (wa[p] == ra[r]) && (wa[p] != 6'd0)) begin
                        e_data = wd[p];
                        e_hit = 1'b1;
                    end
                end
                e_busy = m_pend[ra[r]];
                if (e_hit && !(rv && (rv_a == ra[r]))) e_busy = 1'b0;
                check_eq("rnd_rdata", b_rdata[r*32 +: 32], e_data);
                check_eq("rnd_rbusy", 32'(b_rbusy[r]), 32'(e_busy));
            end
            check_eq("rnd_any", 32'(b_any), 32'(e_any));
            for (int p = 0; p < 4; p++) begin
                if (wev[p] && (wa[p] != 6'd0)) begin
                    m_mem[wa[p]] = wd[p];
                    m_pend[wa[p]] = 1'b0;
                end
            end
            if (rv && (rv_a != 6'd0)) m_pend[rv_a] = 1'b1;
            tick();
        end
        b_we = 4'b0000;
        b_rsv_v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
